cache_controller: RTL and testbench
===================================

// Module: cache_controller
// PURPOSE
// - MEM-stage initiator for the 2-way data cache. Translates CPU byte addresses to cache word addresses and drives cache read/write/invoke.
// - Fills the cache from SRAM on read miss: 64-bit block, two words.
// - Write-through, no-allocate: a write invalidates a hit line and then writes SRAM.
// - Drives pipeline freeze through ready=0 while an SRAM transaction is outstanding.
// PARAMETERS
// BASE_ADDR   1024  CPU byte address mapped to cache/SRAM word 0
// CADDR_W     17    cache word-address width; bit 0 = word offset in block
// CNT_W       16    width of saturating hit/miss counters
// PORTS
// clk               in   1        rising-edge clock
// rst               in   1        asynchronous, active-low reset
// mem_r_en          in   1        load request, held by stalled pipeline until ready
// mem_w_en          in   1        store request, held until ready
// address           in   32       CPU byte address
// wdata             in   32       store data
// rdata             out  32       load data, valid when ready&&mem_r_en
// ready             out  1        request completes this cycle; ~ready freezes pipeline
// cache_address     out  CADDR_W  (address-BASE_ADDR)[CADDR_W+1:2]
// cache_write_data  out  64       fill block = sram_rdata
// cache_read_en     out  1        read probe (updates LRU on hit)
// cache_write_en    out  1        fill strobe
// cache_invoke      out  1        invalidate strobe
// cache_read_data   in   32       cache word output
// cache_hit         in   1        combinational hit for cache_address
// sram_address      out  32       = address, passed through
// sram_wdata        out  32       = wdata
// sram_r_en         out  1        SRAM 64-bit block read request, level until sram_ready
// sram_w_en         out  1        SRAM 32-bit word write request, level until sram_ready
// sram_rdata        in   64       block; [31:0] = even word, [63:32] = odd word
// sram_ready        in   1        one-cycle completion pulse
// hit_count         out  CNT_W    read hits, saturating
// miss_count        out  CNT_W    read misses, saturating
// BEHAVIOUR
// - States: IDLE, RD_MISS, WR. The state register and counters are the only flops. rst=0 -> IDLE, counters 0.
// - All other outputs decode combinationally from state and inputs. In IDLE with no request: ready=1; all enables 0; rdata=0.
// - mem_w_en has priority if both requests are asserted.
// - IDLE, read:
//   - cache_read_en=1.
//   - Hit: rdata=cache_read_data, ready=1, hit_count++. Zero-cycle latency; stay in IDLE.
//   - Miss: ready=0, sram_r_en=1 in the same cycle, miss_count++. -> RD_MISS.
// - RD_MISS:
//   - sram_r_en=1, ready=0, cache_read_en=0.
//   - On sram_ready: cache_write_en=1, ready=1. rdata = cache_address[0] ? sram_rdata[63:32] : sram_rdata[31:0]. -> IDLE.
// - IDLE, write: cache_invoke=1 for exactly this cycle (a miss is a no-op in the cache); sram_w_en=1; ready=0; -> WR.
// - WR: sram_w_en=1, ready=0. On sram_ready: ready=1, -> IDLE. The cache is never written on a store.
// - sram_ready in IDLE is ignored.
// - Counters stop at 2^CNT_W-1.
// - Address subtraction is modulo 2^32; there is no range check.
// - Reset mid-transaction: immediate return to IDLE, request dropped. SRAM must tolerate the abort.
// - A new request in the cycle after ready=1 is accepted normally; no bubble is required.
// STRUCTURE
// - Shared package: state enum (IDLE/RD_MISS/WR), BASE_ADDR, block/word width constants.
// - Word select reuses the existing 2:1 mux module. No other sub-module.
// TESTING
// 1. Reset: rst=0 during a pending miss -> IDLE; counters 0; sram_r_en=0.
// 2. Read miss then hit:
//    - Load 0x400, sram_rdata=0x0000_BBBB_0000_AAAA after 3 cycles -> ready=0 for 3 cycles; fill strobe; rdata=0xAAAA.
//    - Load 0x404 (hit) -> rdata=0xBBBB, ready same cycle.
//    - hit=1, miss=1.
// 3. Store to a cached word: store 0x400 data 0x1234 -> cache_invoke for 1 cycle; sram_w_en until sram_ready; next load 0x400 misses.
// 4. Simultaneous mem_r_en&mem_w_en -> write path taken; no cache_read_en.
// 5. Back-to-back: miss completes, then a hit the next cycle -> no idle bubble.
// 6. Counter saturation: CNT_W=2, 5 hits -> hit_count=3.

Source files
------------

// File: rtl/cache_controller_pkg.sv
// Shared definitions for the MEM-stage data-cache controller: FSM states,
// the CPU-to-cache address base and the word/block widths.
package cache_controller_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR      = 2'd2
    } state_t;

    localparam logic [31:0] BASE_ADDR = 32'd1024;
    localparam int          WORD_W    = 32;
    localparam int          BLOCK_W   = 64;

endpackage

// File: rtl/cache_controller_mux2.sv
// Generic 2:1 mux; the controller uses it to pick the requested word
// out of a 64-bit SRAM fill block.
module cache_controller_mux2 #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/cache_controller.sv
// MEM-stage initiator for the 2-way data cache: zero-latency read hits, block
// fill on read miss, write-through no-allocate stores, pipeline freeze via ready.
//
// state   | meaning
// IDLE    | no SRAM transaction outstanding; hits and new requests served here
// RD_MISS | 64-bit block read from SRAM in flight; fill + return word on sram_ready
// WR      | 32-bit word write to SRAM in flight; completes on sram_ready
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int CADDR_W = 17,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [CADDR_W-1:0] cache_address,
    output logic [63:0]        cache_write_data,
    output logic               cache_read_en,
    output logic               cache_write_en,
    output logic               cache_invoke,
    input  logic [31:0]        cache_read_data,
    input  logic               cache_hit,
    output logic [31:0]        sram_address,
    output logic [31:0]        sram_wdata,
    output logic               sram_r_en,
    output logic               sram_w_en,
    input  logic [63:0]        sram_rdata,
    input  logic               sram_ready,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count
);

    state_t              state;
    logic [31:0]         offset;
    logic [WORD_W-1:0]   fill_word;
    logic                read_req;
    logic                unused_offset_bits;

    // Byte offset from the mapped base wraps modulo 2^32; no range check.
    assign offset             = address - BASE_ADDR;
    assign cache_address      = offset[CADDR_W+1:2];
    assign unused_offset_bits = ^{offset[31:CADDR_W+2], offset[1:0]};

    assign cache_write_data = sram_rdata;
    assign sram_address     = address;
    assign sram_wdata       = wdata;

    // A store wins when both requests are presented together.
    assign read_req = mem_r_en && !mem_w_en;

    cache_controller_mux2 #(.W(WORD_W)) u_word_sel (
        .sel (cache_address[0]),
        .d0  (sram_rdata[WORD_W-1:0]),
        .d1  (sram_rdata[BLOCK_W-1:WORD_W]),
        .y   (fill_word)
    );

    always_comb begin
        ready          = 1'b1;
        rdata          = '0;
        cache_read_en  = 1'b0;
        cache_write_en = 1'b0;
        cache_invoke   = 1'b0;
        sram_r_en      = 1'b0;
        sram_w_en      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_w_en) begin
                    cache_invoke = 1'b1;
                    sram_w_en    = 1'b1;
                    ready        = 1'b0;
                end else if (mem_r_en) begin
                    cache_read_en = 1'b1;
                    if (cache_hit) begin
                        rdata = cache_read_data;
                    end else begin
                        ready     = 1'b0;
                        sram_r_en = 1'b1;
                    end
                end
            end
            RD_MISS: begin
                sram_r_en = 1'b1;
                ready     = 1'b0;
                if (sram_ready) begin
                    cache_write_en = 1'b1;
                    ready          = 1'b1;
                    rdata          = fill_word;
                end
            end
            WR: begin
                sram_w_en = 1'b1;
                ready     = sram_ready;
            end
            default: begin
                ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_w_en) begin
                        state <= WR;
                    end else if (read_req) begin
                        if (cache_hit) begin
                            if (hit_count != '1)
                                hit_count <= hit_count + CNT_W'(1);
                        end else begin
                            if (miss_count != '1)
                                miss_count <= miss_count + CNT_W'(1);
                            state <= RD_MISS;
                        end
                    end
                end
                RD_MISS: if (sram_ready) state <= IDLE;
                WR:      if (sram_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench: the bench plays cache and SRAM, and predicts each
// transaction from a word-level memory image and a set of cached blocks.
module tb_cache_controller;

    localparam int CADDR_W = 17;
    localparam int CNT_W   = 2;
    localparam int CMAX    = 3;

    logic               clk;
    logic               rst;
    logic               mem_r_en;
    logic               mem_w_en;
    logic [31:0]        address;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               ready;
    logic [CADDR_W-1:0] cache_address;
    logic [63:0]        cache_write_data;
    logic               cache_read_en;
    logic               cache_write_en;
    logic               cache_invoke;
    logic [31:0]        cache_read_data;
    logic               cache_hit;
    logic [31:0]        sram_address;
    logic [31:0]        sram_wdata;
    logic               sram_r_en;
    logic               sram_w_en;
    logic [63:0]        sram_rdata;
    logic               sram_ready;
    logic [CNT_W-1:0]   hit_count;
    logic [CNT_W-1:0]   miss_count;

    cache_controller #(.CADDR_W(CADDR_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_r_en         (mem_r_en),
        .mem_w_en         (mem_w_en),
        .address          (address),
        .wdata            (wdata),
        .rdata            (rdata),
        .ready            (ready),
        .cache_address    (cache_address),
        .cache_write_data (cache_write_data),
        .cache_read_en    (cache_read_en),
        .cache_write_en   (cache_write_en),
        .cache_invoke     (cache_invoke),
        .cache_read_data  (cache_read_data),
        .cache_hit        (cache_hit),
        .sram_address     (sram_address),
        .sram_wdata       (sram_wdata),
        .sram_r_en        (sram_r_en),
        .sram_w_en        (sram_w_en),
        .sram_rdata       (sram_rdata),
        .sram_ready       (sram_ready),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache stand-in, driven only by the DUT's strobes and address.
    bit          cvalid [0:65535];
    logic [63:0] cdata  [0:65535];

    always_ff @(posedge clk) begin
        if (cache_write_en) begin
            cvalid[cache_address[16:1]] <= 1'b1;
            cdata[cache_address[16:1]]  <= cache_write_data;
        end else if (cache_invoke) begin
            cvalid[cache_address[16:1]] <= 1'b0;
        end
    end

    always_comb begin
        cache_hit       = cvalid[cache_address[16:1]];
        cache_read_data = cache_address[0] ? cdata[cache_address[16:1]][63:32]
                                           : cdata[cache_address[16:1]][31:0];
    end

    // Reference state: memory image by word and blocks expected to be cached.
    logic [31:0] ref_mem    [0:131071];
    bit          ref_cached [0:65535];
    int          ref_hits;
    int          ref_misses;
    int          n_cmp;
    int          n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] word_of(input logic [31:0] a);
        return 17'((a - 32'd1024) / 32'd4);
    endfunction

    // Called at posedge+1; returns at posedge+1 with the request dropped.
    task automatic do_load(input logic [31:0] addr, input int d);
        logic [16:0] w;
        logic [15:0] b;
        logic [63:0] blk;
        bit          hit;
        w   = word_of(addr);
        b   = w[16:1];
        hit = ref_cached[b];
        blk = {ref_mem[{b, 1'b1}], ref_mem[{b, 1'b0}]};
        mem_r_en   = 1'b1;
        mem_w_en   = 1'b0;
        address    = addr;
        sram_rdata = {$urandom, $urandom};
        #1;
        check("ld cache_address", 64'(cache_address), 64'(w));
        check("ld cache_read_en", 64'(cache_read_en), 64'd1);
        if (hit) begin
            check("hit ready", 64'(ready), 64'd1);
            check("hit rdata", 64'(rdata), 64'(ref_mem[w]));
            check("hit sram_r_en", 64'(sram_r_en), 64'd0);
            @(posedge clk); #1;
            if (ref_hits < CMAX) ref_hits++;
        end else begin
            check("miss ready", 64'(ready), 64'd0);
            check("miss sram_r_en", 64'(sram_r_en), 64'd1);
            check("miss fill early", 64'(cache_write_en), 64'd0);
            for (int k = 1; k < d; k++) begin
                @(posedge clk); #1;
                check("wait ready", 64'(ready), 64'd0);
                check("wait sram_r_en", 64'(sram_r_en), 64'd1);
                check("wait cache_read_en", 64'(cache_read_en), 64'd0);
            end
            @(posedge clk); #1;
            sram_ready = 1'b1;
            sram_rdata = blk;
            #1;
            check("fill ready", 64'(ready), 64'd1);
            check("fill strobe", 64'(cache_write_en), 64'd1);
            check("fill data", cache_write_data, blk);
            check("fill rdata", 64'(rdata), 64'(ref_mem[w]));
            @(posedge clk); #1;
            sram_ready    = 1'b0;
            ref_cached[b] = 1'b1;
            if (ref_misses < CMAX) ref_misses++;
        end
        mem_r_en = 1'b0;
        check("hit_count", 64'(hit_count), 64'(ref_hits));
        check("miss_count", 64'(miss_count), 64'(ref_misses));
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                            input int d, input bit both);
        logic [16:0] w;
        w = word_of(addr);
        mem_w_en = 1'b1;
        mem_r_en = both;
        address  = addr;
        wdata    = data;
        #1;
        check("st cache_address", 64'(cache_address), 64'(w));
        check("st invoke", 64'(cache_invoke), 64'd1);
        check("st sram_w_en", 64'(sram_w_en), 64'd1);
        check("st ready", 64'(ready), 64'd0);
        check("st cache_read_en", 64'(cache_read_en), 64'd0);
        check("st sram_r_en", 64'(sram_r_en), 64'd0);
        check("st sram_address", 64'(sram_address), 64'(addr));
        check("st sram_wdata", 64'(sram_wdata), 64'(data));
        for (int k = 1; k < d; k++) begin
            @(posedge clk); #1;
            check("st wait invoke", 64'(cache_invoke), 64'd0);
            check("st wait sram_w_en", 64'(sram_w_en), 64'd1);
            check("st wait ready", 64'(ready), 64'd0);
            check("st wait fill", 64'(cache_write_en), 64'd0);
        end
        @(posedge clk); #1;
        sram_ready = 1'b1;
        #1;
        check("st done ready", 64'(ready), 64'd1);
        check("st done invoke", 64'(cache_invoke), 64'd0);
        check("st done fill", 64'(cache_write_en), 64'd0);
        @(posedge clk); #1;
        sram_ready = 1'b0;
        mem_w_en   = 1'b0;
        mem_r_en   = 1'b0;
        ref_mem[w] = data;
        ref_cached[w[16:1]] = 1'b0;
    endtask

    task automatic idle_cycle(input bit stray);
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        sram_ready = stray;
        #1;
        check("idle ready", 64'(ready), 64'd1);
        check("idle enables", 64'({sram_r_en, sram_w_en, cache_read_en, cache_write_en, cache_invoke}), 64'd0);
        check("idle rdata", 64'(rdata), 64'd0);
        @(posedge clk); #1;
        sram_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        n_cmp = 0; n_err = 0;
        ref_hits = 0; ref_misses = 0;
        for (int i = 0; i < 131072; i++) ref_mem[i] = $urandom;
        rst = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        address = 32'h0; wdata = 32'h0; sram_ready = 1'b0; sram_rdata = 64'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst ready", 64'(ready), 64'd1);
        check("rst hit_count", 64'(hit_count), 64'd0);
        check("rst miss_count", 64'(miss_count), 64'd0);
        rst = 1'b1;

        // Reset while a miss is outstanding.
        @(posedge clk); #1;
        mem_r_en = 1'b1;
        address  = 32'h480;
        #1;
        check("pre-rst sram_r_en", 64'(sram_r_en), 64'd1);
        @(posedge clk); #1;
        check("pre-rst miss_count", 64'(miss_count), 64'd1);
        rst      = 1'b0;
        mem_r_en = 1'b0;
        #1;
        check("abort sram_r_en", 64'(sram_r_en), 64'd0);
        check("abort ready", 64'(ready), 64'd1);
        check("abort miss_count", 64'(miss_count), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed: miss then back-to-back hit on the odd word.
        ref_mem[0] = 32'h0000_AAAA;
        ref_mem[1] = 32'h0000_BBBB;
        do_load(32'h400, 3);
        do_load(32'h404, 1);
        check("dir hit_count", 64'(hit_count), 64'd1);
        check("dir miss_count", 64'(miss_count), 64'd1);

        // Store invalidates; next load of the same word misses and returns new data.
        do_store(32'h400, 32'h1234, 2, 1'b0);
        check("st invalidated", 64'(ref_cached[0]), 64'd0);
        do_load(32'h400, 2);
        check("reload miss_count", 64'(miss_count), 64'd2);

        // Both requests at once: store path.
        do_store(32'h404, 32'h5678, 1, 1'b1);
        idle_cycle(1'b1);

        // Saturation of the 2-bit hit counter.
        do_load(32'h400, 1);
        for (int i = 0; i < 5; i++) do_load(32'h404, 1);
        check("hit saturate", 64'(hit_count), 64'd3);

        // Wrapped address below the base maps to the top cache word.
        do_load(32'h3FC, 2);
        do_load(32'h3F8, 1);

        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 9));
            a  = 32'd1024 + 32'd4 * $urandom_range(0, 63);
            if (op <= 5)      do_load(a, int'($urandom_range(1, 4)));
            else if (op <= 8) do_store(a, $urandom, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
            else              idle_cycle(1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
